// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Instruction memory for the RV32I fetch stage with a byte-stream boot loader.
//   The program image is a 2-byte little-endian word count N followed by 4*N
//   bytes. Each word arrives little-endian. The core is held in reset until the
//   image has been written. After that, InstrF is served combinationally from PCF.
//
// State table:
//   state | meaning
//   HDR0  | waiting for N[7:0]
//   HDR1  | waiting for N[15:8]; range-check N
//   DATA  | assembling and writing image words
//   RUN   | image loaded, core released, fetch served from RAM
//   ERR   | header rejected (N > DEPTH), waiting for reload
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous reset, active low
//   ld_valid     in   load byte present
//   ld_data      in   load byte [7:0]
//   ld_ready     out  byte accepted this cycle (HDR0/HDR1/DATA)
//   reload       in   restart loading (honoured in RUN and ERR only)
//   PCF          in   fetch program counter [31:0]
//   InstrF       out  instruction for PCF [31:0], NOP unless RUN and in range
//   core_hold    out  keep the core in reset (every state except RUN)
//   load_err     out  header rejected
//   words_loaded out  words written by the current load [16:0]

module imem_boot_loader #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic        reload,
    input  logic [31:0] PCF,
    output logic [31:0] InstrF,
    output logic        core_hold,
    output logic        load_err,
    output logic [16:0] words_loaded
);

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [16:0] DEPTH17 = 17'(DEPTH);

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] asm_q, asm_d;
    logic [16:0] words_q, words_d;
    logic        err_q, err_d;

    logic        xfer;
    logic [15:0] hdr_n;
    logic [16:0] words_inc;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] fetch_idx;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HDR0;
            n_q        <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            words_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            words_q    <= words_d;
            err_q      <= err_d;
        end
    end

    // RAM contents survive reset and reload on purpose.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[words_q[AW-1:0]] <= mem_wdata;
        end
    end

    assign ld_ready  = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    assign xfer      = ld_valid && ld_ready;
    assign hdr_n     = {ld_data, n_q[7:0]};
    assign words_inc = words_q + 17'd1;
    // The assembly register shifts right, so after three bytes it holds
    // {b2, b1, b0}. The fourth byte completes the word on the same edge.
    assign mem_wdata = {ld_data, asm_q};

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        words_d    = words_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        case (state_q)
            HDR0: begin
                if (xfer) begin
                    n_d[7:0] = ld_data;
                    state_d  = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    n_d        = hdr_n;
                    byte_idx_d = '0;
                    words_d    = '0;
                    if (hdr_n == 16'd0) begin
                        state_d = RUN;
                    end else if ({1'b0, hdr_n} > DEPTH17) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    if (byte_idx_q == 2'd3) begin
                        mem_we     = 1'b1;
                        words_d    = words_inc;
                        byte_idx_d = '0;
                        if (words_inc == {1'b0, n_q}) begin
                            state_d = RUN;
                        end
                    end else begin
                        asm_d      = {ld_data, asm_q[23:8]};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            RUN: begin
                if (reload) begin
                    state_d = HDR0;
                    words_d = '0;
                end
            end
            ERR: begin
                if (reload) begin
                    state_d = HDR0;
                    err_d   = 1'b0;
                    words_d = '0;
                end
            end
            default: begin
                state_d = HDR0;
            end
        endcase
    end

    // Shift rather than slice so every PC bit takes part in the range check.
    assign fetch_idx = PCF >> 2;

    always_comb begin
        InstrF = NOP;
        if ((state_q == RUN) && (fetch_idx < 32'(DEPTH))) begin
            InstrF = mem[fetch_idx[AW-1:0]];
        end
    end

    assign core_hold    = (state_q != RUN);
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader (DEPTH = 256).
module tb_imem_boot_loader;

    logic        clk;
    logic        reset;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        reload;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        core_hold;
    logic        load_err;
    logic [16:0] words_loaded;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    imem_boot_loader #(.DEPTH(256)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .reload       (reload),
        .PCF          (PCF),
        .InstrF       (InstrF),
        .core_hold    (core_hold),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offers one byte and checks that it is accepted on the next edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        ld_valid = 1'b1;
        ld_data  = b;
        total++;
        if (ld_ready !== 1'b1) begin
            bad++;
            $display("FAIL ld_ready_on_byte got=%0b want=1 byte=%02h", ld_ready, b);
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #7;
        reset = 1'b0;
        #1;
        total++; if (core_hold !== 1'b1)   begin bad++; $display("FAIL reset_core_hold got=%0b want=1", core_hold); end
        total++; if (ld_ready !== 1'b1)    begin bad++; $display("FAIL reset_ld_ready got=%0b want=1", ld_ready); end
        total++; if (load_err !== 1'b0)    begin bad++; $display("FAIL reset_load_err got=%0b want=0", load_err); end
        total++; if (InstrF !== NOP)       begin bad++; $display("FAIL reset_instr got=%08h want=%08h", InstrF, NOP); end
        total++; if (words_loaded !== 17'd0) begin bad++; $display("FAIL reset_words got=%0d want=0", words_loaded); end
        #6;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] img [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                  8'h13, 8'h01, 8'hA1, 8'h00};
        for (int i = 0; i < 10; i++) send_byte(img[i], 1'b0);
        total++; if (core_hold !== 1'b0)     begin bad++; $display("FAIL b2b_core_hold got=%0b want=0", core_hold); end
        total++; if (ld_ready !== 1'b0)      begin bad++; $display("FAIL b2b_ld_ready got=%0b want=0", ld_ready); end
        total++; if (words_loaded !== 17'd2) begin bad++; $display("FAIL b2b_words got=%0d want=2", words_loaded); end
        PCF = 32'd0; #1;
        total++; if (InstrF !== 32'h00500093) begin bad++; $display("FAIL b2b_word0 got=%08h want=00500093", InstrF); end
        PCF = 32'd4; #1;
        total++; if (InstrF !== 32'h00A10113) begin bad++; $display("FAIL b2b_word1 got=%08h want=00a10113", InstrF); end
    endtask

    task automatic test_gap_load();
        logic [7:0] junk [10] = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                                   8'h88, 8'h77, 8'h66, 8'h55};
        logic [7:0] img [10]  = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                   8'h13, 8'h01, 8'hA1, 8'h00};
        pulse_reload();
        total++; if (core_hold !== 1'b1) begin bad++; $display("FAIL reload_core_hold got=%0b want=1", core_hold); end
        PCF = 32'd0; #1;
        total++; if (InstrF !== NOP)     begin bad++; $display("FAIL reload_instr got=%08h want=%08h", InstrF, NOP); end
        for (int i = 0; i < 10; i++) send_byte(junk[i], 1'b0);
        PCF = 32'd4; #1;
        total++; if (InstrF !== 32'h55667788) begin bad++; $display("FAIL junk_word1 got=%08h want=55667788", InstrF); end
        pulse_reload();
        for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
        total++; if (words_loaded !== 17'd2) begin bad++; $display("FAIL gap_words got=%0d want=2", words_loaded); end
        PCF = 32'd0; #1;
        total++; if (InstrF !== 32'h00500093) begin bad++; $display("FAIL gap_word0 got=%08h want=00500093", InstrF); end
        PCF = 32'd4; #1;
        total++; if (InstrF !== 32'h00A10113) begin bad++; $display("FAIL gap_word1 got=%08h want=00a10113", InstrF); end
    endtask

    task automatic test_zero_header();
        pulse_reload();
        total++; if (words_loaded !== 17'd0) begin bad++; $display("FAIL reload_clears_words got=%0d want=0", words_loaded); end
        send_byte(8'h00, 1'b0);
        total++; if (core_hold !== 1'b1) begin bad++; $display("FAIL zero_hdr_mid got=%0b want=1", core_hold); end
        send_byte(8'h00, 1'b0);
        total++; if (core_hold !== 1'b0)     begin bad++; $display("FAIL zero_hdr_run got=%0b want=0", core_hold); end
        total++; if (words_loaded !== 17'd0) begin bad++; $display("FAIL zero_hdr_words got=%0d want=0", words_loaded); end
        PCF = 32'd4; #1;
        total++; if (InstrF !== 32'h00A10113) begin bad++; $display("FAIL zero_hdr_keeps got=%08h want=00a10113", InstrF); end
    endtask

    task automatic test_err();
        logic [7:0] img [6] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        pulse_reload();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        total++; if (load_err !== 1'b1)  begin bad++; $display("FAIL err_flag got=%0b want=1", load_err); end
        total++; if (core_hold !== 1'b1) begin bad++; $display("FAIL err_core_hold got=%0b want=1", core_hold); end
        total++; if (ld_ready !== 1'b0)  begin bad++; $display("FAIL err_ld_ready got=%0b want=0", ld_ready); end
        ld_valid = 1'b1;
        ld_data  = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        ld_valid = 1'b0;
        total++; if (load_err !== 1'b1 || ld_ready !== 1'b0) begin
            bad++; $display("FAIL err_stays got=err%0b/rdy%0b want=err1/rdy0", load_err, ld_ready);
        end
        pulse_reload();
        total++; if (load_err !== 1'b0)  begin bad++; $display("FAIL err_cleared got=%0b want=0", load_err); end
        total++; if (ld_ready !== 1'b1)  begin bad++; $display("FAIL err_to_hdr0 got=%0b want=1", ld_ready); end
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0);
        total++; if (words_loaded !== 17'd1) begin bad++; $display("FAIL err_reload_words got=%0d want=1", words_loaded); end
        PCF = 32'd0; #1;
        total++; if (InstrF !== 32'h12345678) begin bad++; $display("FAIL err_reload_word0 got=%08h want=12345678", InstrF); end
    endtask

    task automatic test_out_of_range();
        PCF = 32'd1024; #1;
        total++; if (InstrF !== NOP) begin bad++; $display("FAIL pcf_depth got=%08h want=%08h", InstrF, NOP); end
        PCF = 32'hFFFF_FFFC; #1;
        total++; if (InstrF !== NOP) begin bad++; $display("FAIL pcf_high got=%08h want=%08h", InstrF, NOP); end
        PCF = 32'd7; #1;
        total++; if (InstrF !== 32'h00A10113) begin bad++; $display("FAIL pcf_low_bits got=%08h want=00a10113", InstrF); end
        PCF = 32'd3; #1;
        total++; if (InstrF !== 32'h12345678) begin bad++; $display("FAIL pcf_low_bits0 got=%08h want=12345678", InstrF); end
    endtask

    task automatic test_reload_new();
        logic [7:0] img [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pulse_reload();
        for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0);
        PCF = 32'd0; #1;
        total++; if (InstrF !== 32'hDEADBEEF) begin bad++; $display("FAIL new_word0 got=%08h want=deadbeef", InstrF); end
        PCF = 32'd4; #1;
        total++; if (InstrF !== 32'h00A10113) begin bad++; $display("FAIL new_word1_kept got=%08h want=00a10113", InstrF); end
    endtask

    task automatic test_reload_in_data();
        pulse_reload();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        pulse_reload();
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL data_reload_ignored got=%0b want=1", ld_ready); end
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        total++; if (core_hold !== 1'b0 || words_loaded !== 17'd1) begin
            bad++; $display("FAIL data_reload_run got=hold%0b/words%0d want=hold0/words1", core_hold, words_loaded);
        end
        PCF = 32'd0; #1;
        total++; if (InstrF !== 32'hDDCCBBAA) begin bad++; $display("FAIL data_reload_word got=%08h want=ddccbbaa", InstrF); end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] img [7] = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        pulse_reload();
        for (int i = 0; i < 7; i++) send_byte(img[i], 1'b0);
        total++; if (words_loaded !== 17'd1) begin bad++; $display("FAIL midload_words got=%0d want=1", words_loaded); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (words_loaded !== 17'd0) begin bad++; $display("FAIL midreset_words got=%0d want=0", words_loaded); end
        total++; if (ld_ready !== 1'b1 || core_hold !== 1'b1) begin
            bad++; $display("FAIL midreset_state got=rdy%0b/hold%0b want=rdy1/hold1", ld_ready, core_hold);
        end
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        PCF = 32'd0; #1;
        total++; if (InstrF !== 32'h04030201) begin bad++; $display("FAIL midreset_word0_kept got=%08h want=04030201", InstrF); end
        PCF = 32'd4; #1;
        total++; if (InstrF !== 32'h00A10113) begin bad++; $display("FAIL midreset_word1_kept got=%08h want=00a10113", InstrF); end
    endtask

    initial begin
        reset    = 1'b1;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        reload   = 1'b0;
        PCF      = 32'd0;
        test_reset();
        test_back_to_back();
        test_gap_load();
        test_zero_header();
        test_err();
        test_out_of_range();
        test_reload_new();
        test_reload_in_data();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Instruction-memory block feeding the fetch stage of the 5-stage RV32I pipeline. Receives a program image over a byte-wide valid/ready stream and writes it into an internal word-addressed instruction RAM, holding the core in reset until loading completes. It then serves InstrF combinationally from PCF. A reload request re-enters load mode at any time after boot.

## Interface
Parameters:
- DEPTH, 256, instruction RAM size in 32-bit words; power of two, 4..65536.
- AW, $clog2(DEPTH), word-address width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- ld_valid  in  1  load byte present on ld_data.
- ld_data  in  8  load byte.
- ld_ready  out  1  block accepts a byte this cycle.
- reload  in  1  single-cycle request to restart loading; honoured only in RUN and ERR.
- PCF  in  32  fetch-stage program counter from the core.
- InstrF  out  32  instruction word for PCF.
- core_hold  out  1  1 = keep the core in reset; drives the core's reset input.
- load_err  out  1  image header rejected.
- words_loaded  out  17  count of words written in the current load.

## Operation
- Byte transfer happens on a rising edge where ld_valid && ld_ready.
- Image format: 2-byte little-endian word count N, then 4·N bytes. Each word is little-endian: the first byte is bits [7:0].
- States:
  - HDR0: accept N[7:0]; go to HDR1.
  - HDR1: accept N[15:8]. If N == 0, go to RUN. If N > DEPTH, go to ERR. Otherwise go to DATA with word address and byte index at 0.
  - DATA: assemble bytes into a shift/assembly register.
    - On acceptance of byte index 3, write the assembled word to RAM[word address] on that edge.
    - Increment the word address and words_loaded, and reset the byte index.
    - When the incremented count equals N, go to RUN.
  - RUN: ld_ready = 0, core_hold = 0. reload = 1 sends the block to HDR0 and clears words_loaded.
  - ERR: ld_ready = 0, core_hold = 1, load_err = 1. reload = 1 sends the block to HDR0, clears load_err and clears words_loaded.
- ld_ready = 1 exactly in HDR0, HDR1 and DATA. It is a combinational decode of the state register only and never depends on ld_valid.
- core_hold = 1 in every state except RUN.
- Fetch read, combinational:
  - In any state other than RUN, InstrF = 32'h00000013 (NOP).
  - In RUN, if PCF[31:2] < DEPTH, InstrF = RAM[PCF[AW+1:2]]. Otherwise InstrF = 32'h00000013.
  - PCF[1:0] is ignored.
- RAM words beyond N keep their prior contents. They are not cleared by reload or reset.
- reload is ignored in HDR0, HDR1 and DATA. A partial load cannot be aborted except by reset.

## Timing
- Reset values (asynchronous, immediate on reset = 0):
  - state = HDR0, core_hold = 1, load_err = 0, words_loaded = 0.
  - Byte index = 0, assembly register = 0, ld_ready = 1.
  - InstrF = NOP.
  - RAM is not reset.
- Reset asserted mid-load abandons the load. Words already written remain in RAM.
- Latency from the edge accepting the last byte:
  - State is RUN and core_hold = 0 from that edge onward, i.e. in the next cycle.
  - The written word is readable on InstrF in that same next cycle.
- ld_valid may stay high across state changes. Bytes offered in RUN or ERR are not consumed.
- ld_valid gaps inside a word are legal. The byte index holds while there is no transfer.
- reload and the RUN→HDR0 transition:
  - reload sampled high in RUN gives core_hold = 1 after that edge.
  - InstrF is NOP from the following cycle.
  - The first header byte may be accepted on the next edge.
- words_loaded is 17 bits so that N = 65536 is representable. N itself is 16-bit, so DEPTH = 65536 images are limited to 65535 words.

## Test plan
- Reset with reset = 0 mid-cycle → core_hold = 1, ld_ready = 1, load_err = 0 and InstrF = 32'h00000013 immediately, with no clock edge needed.
- Stream 02 00 93 00 50 00 13 01 A1 00 back-to-back → in RUN one cycle after the last byte:
  - words_loaded = 2, core_hold = 0.
  - PCF = 0 gives InstrF = 32'h00500093; PCF = 4 gives 32'h00A10113.
- Same image with ld_valid toggling every other cycle → identical RAM contents. ld_ready stays 1 throughout loading.
- Header 00 00 → RUN one cycle after the second byte, with words_loaded = 0.
- Header with N = DEPTH + 1 (DEPTH = 256: bytes 01 01) → load_err = 1, core_hold = 1, ld_ready = 0 and further bytes are not consumed. Then:
  - A reload pulse gives load_err = 0 and state HDR0.
  - A valid 1-word image then loads correctly.
- In RUN with PCF = DEPTH·4 → InstrF = NOP.
- Reload pulse then a new 1-word image EF BE AD DE (header 01 00) → PCF = 0 gives InstrF = 32'hDEADBEEF, and word 1 retains its old contents.
- Reload asserted during DATA → ignored.
- Reset asserted after 5 data bytes of a 2-word image → back in HDR0 with words_loaded = 0.
